// File: rtl/stats_counter_mem.sv
// Per-ID wide statistics counters held in one single-port RAM. Increments arrive
// over AXI-stream; host software reads the counters one register word at a time.
module stats_counter_mem #(
  parameter int STAT_INC_WIDTH   = 16,
  parameter int STAT_ID_WIDTH    = 5,
  parameter int STAT_COUNT_WIDTH = 64,
  parameter int REG_DATA_WIDTH   = 32,
  parameter int REG_ADDR_WIDTH   = STAT_ID_WIDTH + $clog2(STAT_COUNT_WIDTH / REG_DATA_WIDTH)
                                   + $clog2(REG_DATA_WIDTH / 8)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [STAT_INC_WIDTH-1:0] s_axis_stat_tdata,
  input  logic [STAT_ID_WIDTH-1:0]  s_axis_stat_tid,
  input  logic                      s_axis_stat_tvalid,
  output logic                      s_axis_stat_tready,
  input  logic [REG_ADDR_WIDTH-1:0] reg_rd_addr,
  input  logic                      reg_rd_en,
  output logic [REG_DATA_WIDTH-1:0] reg_rd_data,
  output logic                      reg_rd_wait,
  output logic                      reg_rd_ack
);

  localparam int N_CNT  = 2**STAT_ID_WIDTH;
  localparam int WSEL_W = $clog2(STAT_COUNT_WIDTH / REG_DATA_WIDTH);
  localparam int K_W    = (WSEL_W > 0) ? WSEL_W : 1;
  localparam int BYTE_W = $clog2(REG_DATA_WIDTH / 8);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_UPDATE, ST_READ} state_t;

  state_t                      r_state;
  logic [STAT_ID_WIDTH-1:0]    r_init_idx;
  logic [STAT_ID_WIDTH-1:0]    r_id;
  logic [STAT_INC_WIDTH-1:0]   r_inc;
  logic [K_W-1:0]              r_k;
  logic                        r_prio_rd;
  logic                        r_ack;
  logic [REG_DATA_WIDTH-1:0]   r_rd_data;
  logic [STAT_COUNT_WIDTH-1:0] r_mem [0:N_CNT-1];
  logic [STAT_COUNT_WIDTH-1:0] r_ram_q;

  logic                        w_rd_req;
  logic                        w_idle;
  logic                        w_tready;
  logic                        w_inc_fire;
  logic                        w_rd_fire;
  logic [STAT_ID_WIDTH-1:0]    w_rd_id;
  logic [K_W-1:0]              w_rd_k;
  logic                        w_unused_addr;
  logic                        w_ram_we;
  logic [STAT_ID_WIDTH-1:0]    w_ram_addr;
  logic [STAT_COUNT_WIDTH-1:0] w_ram_wdata;

  // Byte offset bits below the word are ignored; the xor only marks them as read.
  assign w_unused_addr = ^reg_rd_addr;
  assign w_rd_id       = reg_rd_addr[BYTE_W+WSEL_W +: STAT_ID_WIDTH];
  assign w_rd_k        = (WSEL_W == 0) ? '0 : reg_rd_addr[BYTE_W +: K_W];

  // The ack cycle masks the still-high reg_rd_en so one request never acks twice.
  assign w_rd_req   = reg_rd_en && !r_ack;
  assign w_idle     = (r_state == ST_IDLE);
  assign w_tready   = w_idle && !(w_rd_req && r_prio_rd);
  assign w_inc_fire = w_tready && s_axis_stat_tvalid;
  assign w_rd_fire  = w_idle && w_rd_req && !w_inc_fire;

  assign s_axis_stat_tready = rst_n && w_tready;
  assign reg_rd_wait        = rst_n && w_rd_req;
  assign reg_rd_ack         = r_ack;
  assign reg_rd_data        = r_rd_data;

  // NOTE: every signal assigned here gets a default first, so no latch is inferred.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_addr  = r_id;
    w_ram_wdata = r_ram_q + STAT_COUNT_WIDTH'(r_inc);
    case (r_state)
      ST_INIT: begin
        w_ram_we    = rst_n;
        w_ram_addr  = r_init_idx;
        w_ram_wdata = '0;
      end
      ST_IDLE:   w_ram_addr = w_rd_fire ? w_rd_id : s_axis_stat_tid;
      ST_UPDATE: w_ram_we   = rst_n;
      default:   w_ram_we   = 1'b0;
    endcase
  end

  // NOTE: the counter RAM has no reset; the INIT sweep clears it instead.
  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdata;
    r_ram_q <= r_mem[w_ram_addr];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
      r_id       <= '0;
      r_inc      <= '0;
      r_k        <= '0;
      r_prio_rd  <= 1'b0;
      r_ack      <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_INIT: begin
          r_init_idx <= r_init_idx + STAT_ID_WIDTH'(1);
          if (r_init_idx == '1) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (w_inc_fire) begin
            r_id    <= s_axis_stat_tid;
            r_inc   <= s_axis_stat_tdata;
            r_state <= ST_UPDATE;
          end else if (w_rd_fire) begin
            r_id    <= w_rd_id;
            r_k     <= w_rd_k;
            r_state <= ST_READ;
          end
        end
        ST_UPDATE: begin
          r_prio_rd <= 1'b1;
          r_state   <= ST_IDLE;
        end
        ST_READ: begin
          r_rd_data <= r_ram_q[int'(r_k)*REG_DATA_WIDTH +: REG_DATA_WIDTH];
          r_ack     <= 1'b1;
          r_prio_rd <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

endmodule
